// File: rtl/arb_pkg.sv
// Shared constants and types for the 16-requester round-robin arbiter.
// Imported by the arbiter top, its priority encoder and its bus interface.
package arb_pkg;

  localparam int N                = 16;
  localparam int IDX_W            = 4;
  localparam int MAX_HOLD_DEFAULT = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// gnt_idx is intended to drive the shared resource mux select directly.
interface rr_arbiter16_if;
  import arb_pkg::*;

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_prio_enc16.sv
// Combinational rotating priority encoder: returns the first set request bit
// at or above ptr, wrapping from 15 to 0.
module rr_prio_enc16
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] offset;

  // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit
  // is the distance from ptr; adding ptr back wraps naturally in IDX_W bits.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    offset  = '0;
    found   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_W'(i);
        found  = 1'b1;
      end
    end
    idx = offset + ptr;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Sixteen-requester round-robin arbiter with registered one-hot grant,
// binary grant index, owner release via done/withdraw, and hold timeout.
module rr_arbiter16 #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter16_if.slave  bus
);

  localparam int HCNT_W = $clog2(MAX_HOLD + 1);

  arb_pkg::state_e   state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              owner_req;
  logic              hold_hit;
  logic              release_now;

  rr_prio_enc16 u_prio_enc (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    owner_req   = bus.req[gnt_idx_q];
    hold_hit    = (hcnt_q == HCNT_W'(MAX_HOLD - 1));
    release_now = bus.done | ~owner_req | hold_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= arb_pkg::IDLE;
      ptr_q       <= '0;
      hcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hcnt_q      <= hcnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      arb_pkg::IDLE:  if (pick_found)  state_d = arb_pkg::GRANT;
      arb_pkg::GRANT: if (release_now) state_d = arb_pkg::IDLE;
      default:                         state_d = arb_pkg::IDLE;
    endcase
  end

  // done is only looked at in GRANT, so a done overlapping the pick edge is
  // ignored; timeout flags a release caused purely by the hold limit.
  always_comb begin
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      arb_pkg::IDLE: begin
        if (pick_found) begin
          gnt_d       = N'(1) << pick_idx;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hcnt_d      = '0;
        end
      end
      arb_pkg::GRANT: begin
        if (release_now) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IDX_W'(1);
          timeout_d   = hold_hit & ~bus.done & owner_req;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 (hold limit 4) and rr_prio_enc16, checked
// against a cycle model of the arbitration rules plus literal expectations.
module tb_rr_arbiter16;

  localparam int MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.N(16), .IDX_W(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] enc_req;
  logic [3:0]  enc_ptr;
  logic [3:0]  enc_idx;
  logic        enc_found;

  rr_prio_enc16 u_enc (
    .req   (enc_req),
    .ptr   (enc_ptr),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always #5 clk = ~clk;

  // Scan upward from p, wrapping at 16; -1 when nobody is requesting.
  function automatic int pick(logic [15:0] r, int p);
    for (int o = 0; o < 16; o++) begin
      if (r[(p + o) % 16]) return (p + o) % 16;
    end
    return -1;
  endfunction

  // Model state: current owner (-1 when idle), last granted index, pointer,
  // number of cycles the current grant has been visible, timeout pulse.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 0;
      m_ptr   <= 0;
      m_held  <= 0;
      m_tmo   <= 1'b0;
    end else begin : model_step
      int  k;
      bit  forced;
      m_tmo <= 1'b0;
      if (m_owner < 0) begin
        k = pick(bus.req, m_ptr);
        if (k >= 0) begin
          m_owner <= k;
          m_last  <= k;
          m_held  <= 1;
        end
      end else begin
        forced = (m_held == MAX_HOLD);
        if (bus.done || !bus.req[m_owner] || forced) begin
          m_tmo   <= forced && !bus.done && bus.req[m_owner];
          m_ptr   <= (m_owner + 1) % 16;
          m_owner <= -1;
        end else begin
          m_held <= m_held + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] exp_gnt;
    logic [3:0]  exp_idx;
    logic        exp_valid;
    exp_gnt   = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0000;
    exp_idx   = 4'(m_last);
    exp_valid = (m_owner >= 0);
    checks++;
    if (bus.gnt !== exp_gnt || bus.gnt_idx !== exp_idx ||
        bus.gnt_valid !== exp_valid || bus.timeout !== m_tmo) begin
      errors++;
      $display("[TB] FAIL model_cycle t=%0t got gnt=%h idx=%0d valid=%b tmo=%b want gnt=%h idx=%0d valid=%b tmo=%b",
               $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
               exp_gnt, exp_idx, exp_valid, m_tmo);
    end
    checks++;
    if (!$onehot0(bus.gnt) || (!bus.gnt_valid && bus.gnt != 16'h0000)) begin
      errors++;
      $display("[TB] FAIL grant_invariant t=%0t got gnt=%h valid=%b want onehot0 and zero when invalid",
               $time, bus.gnt, bus.gnt_valid);
    end
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(logic [15:0] r, logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  // Hand-computed encoder vectors: {req, ptr, found, idx}.
  typedef struct {
    logic [15:0] r;
    logic [3:0]  p;
    logic        f;
    logic [3:0]  i;
  } enc_vec_t;

  enc_vec_t enc_vecs[8] = '{
    '{16'h0000, 4'd0,  1'b0, 4'd0},
    '{16'h0010, 4'd0,  1'b1, 4'd4},
    '{16'h8001, 4'd14, 1'b1, 4'd15},
    '{16'h8001, 4'd0,  1'b1, 4'd0},
    '{16'h0031, 4'd5,  1'b1, 4'd5},
    '{16'h0031, 4'd6,  1'b1, 4'd0},
    '{16'hFFFF, 4'd15, 1'b1, 4'd15},
    '{16'h0002, 4'd2,  1'b1, 4'd1}
  };

  logic [15:0] enc_pats[5] = '{16'h0000, 16'h0001, 16'h8000, 16'h0F0F, 16'hA5A4};

  initial begin : stimulus
    bus.req  = '0;
    bus.done = 1'b0;

    foreach (enc_vecs[v]) begin
      enc_req = enc_vecs[v].r;
      enc_ptr = enc_vecs[v].p;
      #1;
      check_output("enc_vec_found", 32'(enc_found), 32'(enc_vecs[v].f));
      if (enc_vecs[v].f) check_output("enc_vec_idx", 32'(enc_idx), 32'(enc_vecs[v].i));
    end
    for (int p = 0; p < 16; p++) begin
      foreach (enc_pats[q]) begin
        enc_req = enc_pats[q];
        enc_ptr = 4'(p);
        #1;
        check_output("enc_sweep_found", 32'(enc_found), 32'(enc_pats[q] != 16'h0000));
        if (enc_pats[q] != 16'h0000)
          check_output("enc_sweep_idx", 32'(enc_idx), 32'(pick(enc_pats[q], p)));
      end
    end

    apply_stimulus(16'h0000, 1'b0);
    apply_stimulus(16'h0000, 1'b0);
    check_output("reset_gnt", 32'(bus.gnt), 32'h0);
    check_output("reset_idx", 32'(bus.gnt_idx), 32'h0);
    check_output("reset_valid", 32'(bus.gnt_valid), 32'h0);
    check_output("reset_timeout", 32'(bus.timeout), 32'h0);
    rst_n = 1'b1;
    apply_stimulus(16'h0000, 1'b0);
    check_output("idle_no_req", 32'(bus.gnt_valid), 32'h0);

    apply_stimulus(16'h0010, 1'b0);
    check_output("single_gnt", 32'(bus.gnt), 32'h0010);
    check_output("single_idx", 32'(bus.gnt_idx), 32'd4);
    apply_stimulus(16'h0010, 1'b1);
    check_output("single_release", 32'(bus.gnt), 32'h0);
    check_output("single_idx_hold", 32'(bus.gnt_idx), 32'd4);
    apply_stimulus(16'h0031, 1'b0);
    check_output("ptr_after_4", 32'(bus.gnt_idx), 32'd5);
    apply_stimulus(16'h0031, 1'b1);

    apply_stimulus(16'h0031, 1'b1);
    check_output("early_done_ignored", 32'(bus.gnt), 32'h0001);
    apply_stimulus(16'h0000, 1'b0);
    check_output("withdraw_release", 32'(bus.gnt_valid), 32'h0);

    rst_n = 1'b0;
    apply_stimulus(16'h0000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(16'hFFFF, 1'b0);
      check_output("rotation_idx", 32'(bus.gnt_idx), 32'(i % 16));
      apply_stimulus(16'hFFFF, 1'b1);
      check_output("rotation_guard", 32'(bus.gnt_valid), 32'h0);
    end

    apply_stimulus(16'h2000, 1'b0);
    check_output("wrap_pre13", 32'(bus.gnt_idx), 32'd13);
    apply_stimulus(16'h2000, 1'b1);
    apply_stimulus(16'h8001, 1'b0);
    check_output("wrap_15", 32'(bus.gnt), 32'h8000);
    apply_stimulus(16'h8001, 1'b1);
    apply_stimulus(16'h8001, 1'b0);
    check_output("wrap_0", 32'(bus.gnt), 32'h0001);
    apply_stimulus(16'h8001, 1'b1);

    for (int c = 0; c < 4; c++) begin
      apply_stimulus(16'h0100, 1'b0);
      check_output("hold_valid", 32'(bus.gnt_valid), 32'h1);
    end
    apply_stimulus(16'h0100, 1'b0);
    check_output("timeout_drop", 32'(bus.gnt), 32'h0);
    check_output("timeout_pulse", 32'(bus.timeout), 32'h1);
    apply_stimulus(16'h0100, 1'b0);
    check_output("timeout_clear", 32'(bus.timeout), 32'h0);
    check_output("timeout_regrant", 32'(bus.gnt), 32'h0100);

    apply_stimulus(16'h0100, 1'b0);
    apply_stimulus(16'h0000, 1'b0);
    check_output("withdraw_valid", 32'(bus.gnt_valid), 32'h0);
    check_output("withdraw_no_tmo", 32'(bus.timeout), 32'h0);

    for (int c = 0; c < 4; c++) apply_stimulus(16'h0100, 1'b0);
    apply_stimulus(16'h0100, 1'b1);
    check_output("simul_valid", 32'(bus.gnt_valid), 32'h0);
    check_output("simul_no_tmo", 32'(bus.timeout), 32'h0);

    apply_stimulus(16'h0200, 1'b0);
    check_output("pre_reset_idx", 32'(bus.gnt_idx), 32'd9);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_gnt", 32'(bus.gnt), 32'h0);
    check_output("async_valid", 32'(bus.gnt_valid), 32'h0);
    apply_stimulus(16'h0201, 1'b0);
    rst_n = 1'b1;
    apply_stimulus(16'h0201, 1'b0);
    check_output("post_reset_pick", 32'(bus.gnt), 32'h0001);
    apply_stimulus(16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
